// File: rtl/dsp_mac_pipe.sv
// Parametrised pre-add / multiply / post-add MAC slice with valid/ready full-pipeline stall.
// Define DSP_MAC_PIPE_SAT_EN to make P saturate on carry (all-ones) or borrow (zero) instead of wrapping.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int IN_STAGES = 1,
  parameter int MREG      = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [B_WIDTH-1:0] D,
  input  logic [P_WIDTH-1:0] C,
  input  logic [P_WIDTH-1:0] PCIN,
  input  logic               CARRYIN,
  input  logic [4:0]         opmode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] P,
  output logic [P_WIDTH-1:0] PCOUT,
  output logic               CARRYOUT
);

  localparam int IW = A_WIDTH + 2*B_WIDTH + P_WIDTH + 6;
  localparam int MW = 2*P_WIDTH + 6;

  logic                       adv;
  logic [IW-1:0]              s0_data;
  logic [IW-1:0]              s1_data;
  logic                       s1_valid;
  logic [4:0]                 op1;
  logic                       cin1;
  logic [P_WIDTH-1:0]         c1;
  logic [B_WIDTH-1:0]         d1;
  logic [B_WIDTH-1:0]         b1;
  logic [A_WIDTH-1:0]         a1;
  logic [B_WIDTH-1:0]         b_pre;
  logic [A_WIDTH+B_WIDTH-1:0] prod;
  logic [P_WIDTH-1:0]         m1;
  logic [MW-1:0]              s1m_data;
  logic [MW-1:0]              s2_data;
  logic                       s2_valid;
  logic [4:0]                 op2;
  logic                       cin2;
  logic [P_WIDTH-1:0]         c2;
  logic [P_WIDTH-1:0]         m2;
  logic [P_WIDTH-1:0]         z;
  logic [P_WIDTH:0]           sum;
  logic [P_WIDTH-1:0]         p_next;

  // The whole pipeline freezes while a finished result waits for the consumer
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign s0_data  = {opmode, CARRYIN, C, D, B, A};

  generate
    if (IN_STAGES == 0) begin : g_in_bypass
      assign s1_data  = s0_data;
      assign s1_valid = in_valid;
    end else begin : g_in_regs
      logic [IN_STAGES-1:0][IW-1:0] in_data;
      logic [IN_STAGES-1:0]         in_vld;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          in_data <= '0;
          in_vld  <= '0;
        end else if (adv) begin
          in_vld[0] <= in_valid;
          if (in_valid) in_data[0] <= s0_data;
          for (int i = 1; i < IN_STAGES; i++) begin
            in_vld[i] <= in_vld[i-1];
            if (in_vld[i-1]) in_data[i] <= in_data[i-1];
          end
        end
      end

      assign s1_data  = in_data[IN_STAGES-1];
      assign s1_valid = in_vld[IN_STAGES-1];
    end
  endgenerate

  assign {op1, cin1, c1, d1, b1, a1} = s1_data;

  always_comb begin
    b_pre = b1;
    if (op1[0]) b_pre = op1[1] ? (d1 - b1) : (d1 + b1);
  end

  assign prod     = {{B_WIDTH{1'b0}}, a1} * {{A_WIDTH{1'b0}}, b_pre};
  assign m1       = {{(P_WIDTH-A_WIDTH-B_WIDTH){1'b0}}, prod};
  assign s1m_data = {op1, cin1, c1, m1};

  generate
    if (MREG == 0) begin : g_m_bypass
      assign s2_data  = s1m_data;
      assign s2_valid = s1_valid;
    end else begin : g_m_reg
      logic [MW-1:0] m_data;
      logic          m_vld;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          m_data <= '0;
          m_vld  <= 1'b0;
        end else if (adv) begin
          m_vld <= s1_valid;
          if (s1_valid) m_data <= s1m_data;
        end
      end

      assign s2_data  = m_data;
      assign s2_valid = m_vld;
    end
  endgenerate

  assign {op2, cin2, c2, m2} = s2_data;

  // Z=P reads the live P register, so back-to-back accumulates chain at any latency
  always_comb begin
    z = '0;
    case (op2[3:2])
      2'd1:    z = c2;
      2'd2:    z = P;
      2'd3:    z = PCIN;
      default: z = '0;
    endcase
  end

  always_comb begin
    sum = {1'b0, z} + {1'b0, m2} + {{P_WIDTH{1'b0}}, cin2};
    if (op2[4]) sum = {1'b0, z} - ({1'b0, m2} + {{P_WIDTH{1'b0}}, cin2});
  end

`ifdef DSP_MAC_PIPE_SAT_EN
  always_comb begin
    p_next = sum[P_WIDTH-1:0];
    if (sum[P_WIDTH]) p_next = op2[4] ? '0 : '1;
  end
`else
  assign p_next = sum[P_WIDTH-1:0];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P         <= '0;
      CARRYOUT  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        P        <= p_next;
        CARRYOUT <= sum[P_WIDTH];
      end
    end
  end

  assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: vector table, hand sequences for accumulate/stall/reset,
// and a randomized run scored against an arithmetic reference model.
module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam logic [PW-1:0] ALL_ONES = '1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic [BW-1:0] D = '0;
  logic [PW-1:0] C = '0;
  logic [PW-1:0] PCIN = '0;
  logic          CARRYIN = 1'b0;
  logic [4:0]    opmode = '0;

  logic          ir0, ov0, co0;
  logic [PW-1:0] p0, pc0;
  logic          ir1, ov1, co1;
  logic [PW-1:0] p1, pc1;

  int nChecks = 0;
  int nFails  = 0;

  dsp_mac_pipe u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir0),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .opmode(opmode),
    .out_valid(ov0), .out_ready(out_ready), .P(p0), .PCOUT(pc0), .CARRYOUT(co0)
  );

  // Zero input stages and no M register: latency of one edge
  dsp_mac_pipe #(.IN_STAGES(0), .MREG(0)) u_lat1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir1),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .opmode(opmode),
    .out_valid(ov1), .out_ready(out_ready), .P(p1), .PCOUT(pc1), .CARRYOUT(co1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    logic [4:0]    op;
    logic          cin;
    logic [PW-1:0] exp_p;
    logic          exp_co;
  } vec_t;

  vec_t          vecs[$];
  logic [PW:0]   exp_q[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setBeat(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] d,
                         input logic [PW-1:0] c, input logic [4:0] op, input logic cin);
    A = a; B = b; D = d; C = c; opmode = op; CARRYIN = cin;
  endtask

  task automatic doReset();
    RST = 1'b1;
    in_valid = 1'b0;
    setBeat('0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic addVec(input string name, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] d, input logic [PW-1:0] c, input logic [4:0] op,
                        input logic cin, input logic [PW-1:0] exp_p, input logic exp_co);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.d = d; v.c = c; v.op = op; v.cin = cin;
    v.exp_p = exp_p; v.exp_co = exp_co;
    vecs.push_back(v);
  endtask

  // Single beat; returns the number of edges from acceptance until out_valid is seen
  task automatic applyStimulus(input vec_t v, output int lat);
    setBeat(v.a, v.b, v.d, v.c, v.op, v.cin);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!ov0 && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  // Reference result {carry, P} from plain integer arithmetic
  function automatic logic [PW:0] refMac(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                         input logic [BW-1:0] d, input logic [PW-1:0] c,
                                         input logic [PW-1:0] pc, input logic [PW-1:0] pprev,
                                         input logic [4:0] op, input logic cin);
    logic [63:0] bmod, pmod, bp, m, z, mc, full;
    logic        carry;
    bmod = 64'd1 << BW;
    pmod = 64'd1 << PW;
    bp   = 64'(b);
    if (op[0]) bp = op[1] ? (64'(d) + bmod - 64'(b)) % bmod : (64'(d) + 64'(b)) % bmod;
    m = 64'(a) * bp;
    case (op[3:2])
      2'd0:    z = '0;
      2'd1:    z = 64'(c);
      2'd2:    z = 64'(pprev);
      default: z = 64'(pc);
    endcase
    mc = m + 64'(cin);
    if (!op[4]) begin
      full  = z + mc;
      carry = (full >= pmod);
      full  = full % pmod;
    end else begin
      carry = (mc > z);
      full  = (z + pmod - mc) % pmod;
    end
`ifdef DSP_MAC_PIPE_SAT_EN
    if (carry) full = op[4] ? 64'd0 : pmod - 64'd1;
`endif
    return {carry, full[PW-1:0]};
  endfunction

  task automatic scoreDrain();
    logic [PW:0] e;
    checkOutput("sb_has_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_p", 64'(p0), 64'(e[PW-1:0]));
      checkOutput("sb_co", 64'(co0), 64'(e[PW]));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    logic [PW-1:0] acc;
    logic [PW-1:0] p_model;
    logic [PW:0]   e;
    logic          holding;
    int          bseq[7] = '{1, 2, 0, 3, 4, 0, 0};

    doReset();
    checkOutput("rst_p", 64'(p0), 64'd0);
    checkOutput("rst_valid", 64'(ov0), 64'd0);
    checkOutput("rst_co", 64'(co0), 64'd0);
    checkOutput("rst_ready", 64'(ir0), 64'd1);

    addVec("mul",     18'd3,      18'd5,      18'd0,  48'd0,    5'b00000, 1'b0, 48'd15, 1'b0);
    addVec("presub",  18'd2,      18'd4,      18'd10, 48'd0,    5'b00011, 1'b0, 48'd12, 1'b0);
    addVec("preadd",  18'd2,      18'd4,      18'd10, 48'd0,    5'b00001, 1'b0, 48'd28, 1'b0);
    addVec("carryin", 18'd3,      18'd5,      18'd0,  48'd0,    5'b00000, 1'b1, 48'd16, 1'b0);
    addVec("addc",    18'd7,      18'd9,      18'd0,  48'd1000, 5'b00100, 1'b0, 48'd1063, 1'b0);
    addVec("subc",    18'd3,      18'd5,      18'd0,  48'd100,  5'b10100, 1'b0, 48'd85, 1'b0);
    addVec("prewrap", 18'd2,      18'd1,      18'd0,  48'd0,    5'b00011, 1'b0, 48'h7FFFE, 1'b0);
    addVec("bigmul",  18'h3FFFF,  18'h3FFFF,  18'd0,  48'd0,    5'b00000, 1'b0, 48'hF_FFF8_0001, 1'b0);
`ifdef DSP_MAC_PIPE_SAT_EN
    addVec("ovf",     18'd1,      18'd1,      18'd0,  ALL_ONES, 5'b00100, 1'b0, ALL_ONES, 1'b1);
    addVec("borrow",  18'd3,      18'd5,      18'd0,  48'd10,   5'b10100, 1'b0, 48'd0, 1'b1);
`else
    addVec("ovf",     18'd1,      18'd1,      18'd0,  ALL_ONES, 5'b00100, 1'b0, 48'd0, 1'b1);
    addVec("borrow",  18'd3,      18'd5,      18'd0,  48'd10,   5'b10100, 1'b0, 48'hFFFF_FFFF_FFFB, 1'b1);
`endif

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], lat);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'd3);
      checkOutput({vecs[i].name, "_p"}, 64'(p0), 64'(vecs[i].exp_p));
      checkOutput({vecs[i].name, "_pcout"}, 64'(pc0), 64'(vecs[i].exp_p));
      checkOutput({vecs[i].name, "_co"}, 64'(co0), 64'(vecs[i].exp_co));
      tick();
      checkOutput({vecs[i].name, "_valid_drop"}, 64'(ov0), 64'd0);
    end

    // Accumulate chain with one bubble in the middle
    doReset();
    acc = '0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      in_valid = (cyc <= 7) && (bseq[cyc-1] != 0);
      setBeat(18'd1, (cyc <= 7) ? BW'(bseq[cyc-1]) : '0, '0, '0, 5'b01000, 1'b0);
      tick();
      if (cyc >= 3) begin
        if (bseq[cyc-3] != 0) begin
          acc = acc + PW'(bseq[cyc-3]);
          checkOutput("acc_valid", 64'(ov0), 64'd1);
        end else begin
          checkOutput("bubble_valid", 64'(ov0), 64'd0);
        end
        checkOutput("acc_p", 64'(p0), 64'(acc));
      end
    end
    in_valid = 1'b0;

    // Stall: result 15 held while two more beats sit in the pipe and a fourth waits
    doReset();
    out_ready = 1'b0;
    setBeat(18'd3, 18'd5, '0, '0, 5'b00000, 1'b0); in_valid = 1'b1; tick();
    setBeat(18'd1, 18'd2, '0, '0, 5'b00000, 1'b0); tick();
    setBeat(18'd1, 18'd3, '0, '0, 5'b00000, 1'b0); tick();
    setBeat(18'd2, 18'd2, '0, '0, 5'b00000, 1'b0);
    checkOutput("stall_valid", 64'(ov0), 64'd1);
    checkOutput("stall_p", 64'(p0), 64'd15);
    checkOutput("stall_ready", 64'(ir0), 64'd0);
    repeat (3) begin
      tick();
      checkOutput("stall_hold_p", 64'(p0), 64'd15);
      checkOutput("stall_hold_ready", 64'(ir0), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("drain1_p", 64'(p0), 64'd2);
    checkOutput("drain1_valid", 64'(ov0), 64'd1);
    tick();
    checkOutput("drain2_p", 64'(p0), 64'd3);
    tick();
    checkOutput("drain3_p", 64'(p0), 64'd4);
    checkOutput("drain3_valid", 64'(ov0), 64'd1);
    tick();
    checkOutput("drain_done_valid", 64'(ov0), 64'd0);

    // Asynchronous reset with two beats in flight
    setBeat(18'd3, 18'd5, '0, '0, 5'b00000, 1'b0); in_valid = 1'b1; tick();
    setBeat(18'd1, 18'd7, '0, '0, 5'b00000, 1'b0); tick();
    in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    checkOutput("midrst_p", 64'(p0), 64'd0);
    checkOutput("midrst_valid", 64'(ov0), 64'd0);
    checkOutput("midrst_ready", 64'(ir0), 64'd1);
    @(posedge CLK);
    #3 RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("post_rst_no_stale", 64'(ov0), 64'd0);
    end
    checkOutput("post_rst_p", 64'(p0), 64'd0);

    // Single-edge latency slice: accumulate at full rate, then reset mid-flight
    doReset();
    acc = '0;
    for (int k = 1; k <= 3; k++) begin
      setBeat(18'd1, BW'(k), '0, '0, 5'b01000, 1'b0);
      in_valid = 1'b1;
      tick();
      acc = acc + PW'(k);
      checkOutput("lat1_p", 64'(p1), 64'(acc));
      checkOutput("lat1_pcout", 64'(pc1), 64'(acc));
      checkOutput("lat1_valid", 64'(ov1), 64'd1);
      if (k == 1) checkOutput("lat3_not_yet", 64'(ov0), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("lat1_drop", 64'(ov1), 64'd0);
    checkOutput("lat1_hold", 64'(p1), 64'd6);
    checkOutput("lat1_co", 64'(co1), 64'd0);
    setBeat(18'd3, 18'd5, '0, '0, 5'b00000, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("lat1_mul", 64'(p1), 64'd15);
    #2 RST = 1'b1;
    #1;
    checkOutput("lat1_rst_p", 64'(p1), 64'd0);
    checkOutput("lat1_rst_valid", 64'(ov1), 64'd0);
    @(posedge CLK);
    #3 RST = 1'b0;
    tick();
    checkOutput("lat1_no_stale", 64'(ov1), 64'd0);

    // Randomized traffic with random backpressure, scored in acceptance order
    doReset();
    PCIN = PW'({$urandom, $urandom});
    p_model = '0;
    holding = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!holding) begin
        if ($urandom_range(3) != 0) begin
          setBeat(AW'($urandom), BW'($urandom), BW'($urandom), PW'({$urandom, $urandom}),
                  5'($urandom), 1'($urandom));
          in_valid = 1'b1;
          holding  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge CLK);
      if (ov0 && out_ready) scoreDrain();
      if (in_valid && ir0) begin
        e = refMac(A, B, D, C, PCIN, p_model, opmode, CARRYIN);
        p_model = e[PW-1:0];
        exp_q.push_back(e);
        holding = 1'b0;
      end
      @(posedge CLK);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ov0) scoreDrain();
      @(posedge CLK);
      #1;
    end
    checkOutput("sb_all_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
